// File: rtl/s_cell_array.sv
// s_cell_array: WIDTH parallel S-type 4:1 logic cells whose truth tables come from a
// serial configuration chain, with a DEPTH-stage valid-tagged output pipeline.
module s_cell_array #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cfg_shift,
  input  logic             cfg_in,
  output logic             cfg_out,
  output logic             cfg_loaded,
  input  logic             sel_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             out_valid,
  output logic [WIDTH-1:0] out
);

  localparam int CFG_BITS = 4 * WIDTH;
  localparam int CW       = $clog2(CFG_BITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CFG_BITS);

  logic [CFG_BITS-1:0]          cfg_q, cfg_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         shift_prev_q, shift_prev_d;
  logic [DEPTH-1:0][WIDTH-1:0]  data_q, data_d;
  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [WIDTH-1:0]             result;
  logic                         xfer;

  assign in_ready   = !cfg_shift;
  assign xfer       = in_valid && in_ready;
  assign cfg_out    = cfg_q[0];
  assign cfg_loaded = (cnt_q == CNT_FULL) && !cfg_shift;
  assign out        = data_q[DEPTH-1];
  assign out_valid  = vld_q[DEPTH-1];

  // Per-lane cell: {s1,s0} picks one of the lane's four configuration bits.
  always_comb begin
    logic [1:0] sel;
    // NOTE: every variable assigned in always_comb gets a default first so no path leaves it unassigned (which would infer a latch).
    sel    = '0;
    result = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sel[1]    = a1[i] | b1[i];
      sel[0]    = sel_mode ? a0[i] : (a0[i] & b0[i]);
      result[i] = cfg_q[4*i + int'(sel)];
    end
  end

  always_comb begin
    cfg_d        = cfg_q;
    cnt_d        = cnt_q;
    shift_prev_d = cfg_shift;
    if (cfg_shift) begin
      cfg_d = {cfg_in, cfg_q[CFG_BITS-1:1]};
      // A new load burst restarts the count; extra shifts saturate it.
      if (!shift_prev_q)          cnt_d = CW'(1);
      else if (cnt_q != CNT_FULL) cnt_d = cnt_q + CW'(1);
    end
  end

  // Data only advances behind a valid bit, so out holds its last result across bubbles.
  always_comb begin
    data_d    = data_q;
    vld_d     = '0;
    vld_d[0]  = xfer;
    if (xfer) data_d[0] = result;
    for (int k = 1; k < DEPTH; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) data_d[k] = data_q[k-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cfg_q        <= '0;
      cnt_q        <= '0;
      shift_prev_q <= 1'b0;
      data_q       <= '0;
      vld_q        <= '0;
    end else begin
      cfg_q        <= cfg_d;
      cnt_q        <= cnt_d;
      shift_prev_q <= shift_prev_d;
      data_q       <= data_d;
      vld_q        <= vld_d;
    end
  end

endmodule

// File: tb/tb_s_cell_array.sv
// Directed bench for s_cell_array: a DEPTH=2 and a DEPTH=3 instance (WIDTH=4) share stimulus.
module tb_s_cell_array;

  logic       clk, clr, cfg_shift, cfg_in, sel_mode, in_valid;
  logic [3:0] a1, b1, a0, b0;
  logic       cfg_out, cfg_loaded, in_ready, out_valid;
  logic [3:0] out;
  logic       cfg_out3, cfg_loaded3, in_ready3, out_valid3;
  logic [3:0] out3;

  int errors = 0;
  int checks = 0;

  s_cell_array #(.WIDTH(4), .DEPTH(2)) dut (
    .clk(clk), .clr(clr), .cfg_shift(cfg_shift), .cfg_in(cfg_in), .cfg_out(cfg_out),
    .cfg_loaded(cfg_loaded), .sel_mode(sel_mode), .in_valid(in_valid), .in_ready(in_ready),
    .a1(a1), .b1(b1), .a0(a0), .b0(b0), .out_valid(out_valid), .out(out)
  );

  s_cell_array #(.WIDTH(4), .DEPTH(3)) dut3 (
    .clk(clk), .clr(clr), .cfg_shift(cfg_shift), .cfg_in(cfg_in), .cfg_out(cfg_out3),
    .cfg_loaded(cfg_loaded3), .sel_mode(sel_mode), .in_valid(in_valid), .in_ready(in_ready3),
    .a1(a1), .b1(b1), .a0(a0), .b0(b0), .out_valid(out_valid3), .out(out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] v16;
    logic [16:0] v17;
    logic [3:0]  pat [5];
    pat = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF};

    clr = 1'b0; cfg_shift = 1'b0; cfg_in = 1'b0; sel_mode = 1'b0; in_valid = 1'b0;
    a1 = '0; b1 = '0; a0 = '0; b0 = '0;
    #1 clr = 1'b1;
    tick(); tick();
    chk("rst_out", 16'(out), 16'h0);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_cfg_loaded", 16'(cfg_loaded), 16'h0);
    chk("rst_cfg_out", 16'(cfg_out), 16'h0);
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    @(negedge clk) clr = 1'b0;
    tick();

    // Load 16'h6666 LSB first: each lane = {D11,D10,D01,D00} = 0110.
    v16 = 16'h6666;
    for (int i = 0; i < 16; i++) begin
      cfg_shift = 1'b1;
      cfg_in    = v16[i];
      #1;
      chk("load_cfg_out_replay", 16'(cfg_out), 16'h0);
      chk("load_busy_not_loaded", 16'(cfg_loaded), 16'h0);
      if (i == 0) chk("load_in_ready", 16'(in_ready), 16'h0);
      tick();
    end
    cfg_shift = 1'b0; cfg_in = 1'b0;
    #1;
    chk("load_done", 16'(cfg_loaded), 16'h1);

    // Mode 0, s1=0, s0=1 -> D01=1 on every lane.
    a1 = 4'h0; b1 = 4'h0; a0 = 4'hF; b0 = 4'hF; sel_mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("m0_one_cycle_no_valid", 16'(out_valid), 16'h0);
    tick();
    chk("m0_out", 16'(out), 16'hF);
    chk("m0_out_valid", 16'(out_valid), 16'h1);
    tick();
    chk("m0_hold_out", 16'(out), 16'hF);
    chk("m0_hold_valid", 16'(out_valid), 16'h0);

    // Same inputs, mode 1 selects D01 (1), mode 0 selects D00 (0).
    a0 = 4'hF; b0 = 4'h0; sel_mode = 1'b1; in_valid = 1'b1;
    tick();
    sel_mode = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("m1_out", 16'(out), 16'hF);
    chk("m1_valid", 16'(out_valid), 16'h1);
    tick();
    chk("m0b_out", 16'(out), 16'h0);
    chk("m0b_valid", 16'(out_valid), 16'h1);
    tick();
    chk("m0b_drained", 16'(out_valid), 16'h0);

    // Collision: transfer just before a 3-cycle shift of ones; new config becomes 16'hECCC.
    a0 = 4'hF; b0 = 4'hF; sel_mode = 1'b0; in_valid = 1'b1;
    tick();
    cfg_shift = 1'b1; cfg_in = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("coll_in_ready", 16'(in_ready), 16'h0);
      tick();
      chk("coll_cfg_out", 16'(cfg_out), (j == 2) ? 16'h0 : 16'h1);
      if (j == 0) begin
        chk("coll_old_out", 16'(out), 16'hF);
        chk("coll_old_valid", 16'(out_valid), 16'h1);
      end else begin
        chk("coll_no_valid", 16'(out_valid), 16'h0);
      end
    end
    cfg_shift = 1'b0; cfg_in = 1'b0; in_valid = 1'b0;
    #1;
    chk("coll_partial_not_loaded", 16'(cfg_loaded), 16'h0);
    chk("coll_in_ready_back", 16'(in_ready), 16'h1);
    tick();
    chk("coll_dropped_1", 16'(out_valid), 16'h0);
    tick();
    chk("coll_dropped_2", 16'(out_valid), 16'h0);
    chk("coll_hold_out", 16'(out), 16'hF);

    // Under 16'hECCC only lane 3 has D01=1.
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("newcfg_out", 16'(out), 16'h8);
    chk("newcfg_valid", 16'(out_valid), 16'h1);

    // 17 shifts: a leading dummy bit falls off, leaving 16'hAAAA (result = s0).
    v17 = {16'hAAAA, 1'b1};
    for (int i = 0; i < 17; i++) begin
      cfg_shift = 1'b1;
      cfg_in    = v17[i];
      #1;
      if (i == 16) chk("sat_busy_not_loaded", 16'(cfg_loaded), 16'h0);
      tick();
    end
    cfg_shift = 1'b0; cfg_in = 1'b0;
    #1;
    chk("sat_loaded", 16'(cfg_loaded), 16'h1);
    chk("sat_loaded3", 16'(cfg_loaded3), 16'h1);

    // Streaming, mode 1: result lanes = a0.
    sel_mode = 1'b1; a1 = '0; b1 = '0; b0 = '0;
    for (int k = 0; k < 8; k++) begin
      in_valid = (k < 5);
      a0       = (k < 5) ? pat[k] : 4'h0;
      tick();
      chk("stream_d3_valid", 16'(out_valid3), (k >= 2 && k <= 6) ? 16'h1 : 16'h0);
      if (k >= 2 && k <= 6) chk("stream_d3_out", 16'(out3), 16'(pat[k-2]));
      chk("stream_d2_valid", 16'(out_valid), (k >= 1 && k <= 5) ? 16'h1 : 16'h0);
      if (k >= 1 && k <= 5) chk("stream_d2_out", 16'(out), 16'(pat[k-1]));
    end
    chk("stream_d3_hold", 16'(out3), 16'hF);

    // Asynchronous reset mid-cycle with both pipes full.
    in_valid = 1'b1; a0 = 4'hF;
    tick(); tick(); tick();
    chk("prerst_valid3", 16'(out_valid3), 16'h1);
    #2 clr = 1'b1;
    #1;
    chk("async_rst_out", 16'(out), 16'h0);
    chk("async_rst_valid", 16'(out_valid), 16'h0);
    chk("async_rst_loaded", 16'(cfg_loaded), 16'h0);
    chk("async_rst_out3", 16'(out3), 16'h0);
    chk("async_rst_valid3", 16'(out_valid3), 16'h0);
    @(negedge clk) clr = 1'b0; in_valid = 1'b0;
    tick();
    chk("post_rst_valid", 16'(out_valid), 16'h0);
    chk("post_rst_out", 16'(out), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
